// File: rtl/result_write_buffer_if.sv
// Handshake/bus bundle for result_write_buffer.
//   Producer side : wr_req, wr_data, acc_done, clr
//   Consumer side : out_valid, out_ready, out_data
//   Status        : full, empty, count, overflow, drained
// slave is the buffer's view of the bundle; master is the view of the
// block that drives it (wrapper plus consumer).
interface result_write_buffer_if #(
    parameter int WIDTH = 21,
    parameter int AW    = 3
);
    logic             wr_req;
    logic [WIDTH-1:0] wr_data;
    logic             acc_done;
    logic             clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             full;
    logic             empty;
    logic [AW:0]      count;
    logic             overflow;
    logic             drained;

    modport slave (
        input  wr_req, wr_data, acc_done, clr, out_ready,
        output out_valid, out_data, full, empty, count, overflow, drained
    );

    modport master (
        output wr_req, wr_data, acc_done, clr, out_ready,
        input  out_valid, out_data, full, empty, count, overflow, drained
    );
endinterface

// File: rtl/result_write_buffer.sv
// result_write_buffer: captures the accelerator's wr_req/wr_data pulses in a
// synchronous first-word-fall-through FIFO and hands them to a consumer over
// a valid/ready handshake, in arrival order. Remembers the accelerator's done
// pulse and raises drained once done has been seen and the FIFO is empty.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - result_write_buffer_if.slave:
//          wr_req/wr_data  push strobe and word
//          acc_done        done pulse (level accepted)
//          clr             synchronous clear of FIFO, overflow and done_seen
//          out_valid/out_ready/out_data  consumer handshake (data 0 when empty)
//          full/empty/count              occupancy
//          overflow        sticky: a push was dropped
//          drained         done_seen and empty
module result_write_buffer #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic clk,
    input  logic rst,
    result_write_buffer_if.slave bus
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             ovf;
    logic             done_seen;

    logic is_full;
    logic is_empty;
    logic push;
    logic pop;

    assign is_full  = (cnt == (AW+1)'(DEPTH));
    assign is_empty = (cnt == '0);

    // A full FIFO still accepts a word when the head leaves in the same
    // cycle; the freed slot is reused immediately.
    assign pop  = !is_empty && bus.out_ready;
    assign push = bus.wr_req && (!is_full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            done_seen <= 1'b0;
        end else if (bus.clr) begin
            // clr wins over push, pop and acc_done in the same cycle
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            done_seen <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (bus.wr_req && !push) ovf <= 1'b1;
            if (bus.acc_done)        done_seen <= 1'b1;
        end
    end

    // Storage carries no reset; stale contents are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (push && !bus.clr) mem[wr_ptr] <= bus.wr_data;
    end

    assign bus.out_valid = !is_empty;
    assign bus.out_data  = is_empty ? '0 : mem[rd_ptr];
    assign bus.full      = is_full;
    assign bus.empty     = is_empty;
    assign bus.count     = cnt;
    assign bus.overflow  = ovf;
    assign bus.drained   = done_seen && is_empty;

endmodule

// File: tb/tb_result_write_buffer.sv
module tb_result_write_buffer;

    localparam int WIDTH = 21;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    result_write_buffer_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    result_write_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic             wr_req;
        logic [WIDTH-1:0] wr_data;
        logic             out_ready;
        logic             acc_done;
        logic             clr;
        logic             exp_valid;
        logic [WIDTH-1:0] exp_data;
        logic [AW:0]      exp_count;
        logic             exp_full;
        logic             exp_ovf;
        logic             exp_drained;
    } vec_t;

    vec_t vecs[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // inputs: w d r dn c ; expected after the edge: v ed cnt f o dr
    task automatic add(input logic w, input logic [WIDTH-1:0] d, input logic r,
                       input logic dn, input logic c, input logic v,
                       input logic [WIDTH-1:0] ed, input int cnt, input logic f,
                       input logic o, input logic dr);
        vec_t x;
        x.wr_req = w; x.wr_data = d; x.out_ready = r; x.acc_done = dn; x.clr = c;
        x.exp_valid = v; x.exp_data = ed; x.exp_count = (AW+1)'(cnt);
        x.exp_full = f; x.exp_ovf = o; x.exp_drained = dr;
        vecs.push_back(x);
    endtask

    task automatic drive(input logic w, input logic [WIDTH-1:0] d, input logic r,
                         input logic dn, input logic c);
        bus.wr_req = w; bus.wr_data = d; bus.out_ready = r;
        bus.acc_done = dn; bus.clr = c;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic v, input logic [WIDTH-1:0] d,
                             input int cnt, input logic f, input logic o, input logic dr);
        chk({tag, ".valid"},   32'(bus.out_valid), 32'(v));
        chk({tag, ".data"},    32'(bus.out_data),  32'(d));
        chk({tag, ".count"},   32'(bus.count),     32'(cnt));
        chk({tag, ".empty"},   32'(bus.empty),     32'(cnt == 0));
        chk({tag, ".full"},    32'(bus.full),      32'(f));
        chk({tag, ".ovf"},     32'(bus.overflow),  32'(o));
        chk({tag, ".drained"}, 32'(bus.drained),   32'(dr));
    endtask

    initial begin
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);

        // ordered pass-through, then out_ready on an empty FIFO
        add(1, 21'h000001, 0, 0, 0, 1, 21'h000001, 1, 0, 0, 0);
        add(1, 21'h1FFFFF, 0, 0, 0, 1, 21'h000001, 2, 0, 0, 0);
        add(1, 21'h0ABCDE, 0, 0, 0, 1, 21'h000001, 3, 0, 0, 0);
        add(0, 21'h0,      1, 0, 0, 1, 21'h1FFFFF, 2, 0, 0, 0);
        add(0, 21'h0,      1, 0, 0, 1, 21'h0ABCDE, 1, 0, 0, 0);
        add(0, 21'h0,      1, 0, 0, 0, 21'h0,      0, 0, 0, 0);
        add(0, 21'h0,      1, 0, 0, 0, 21'h0,      0, 0, 0, 0);
        add(0, 21'h0,      0, 0, 1, 0, 21'h0,      0, 0, 0, 0);
        // fill 1..8, overflow on 9, pop 1,2, push 10,11 across the wrap
        for (int k = 1; k <= 8; k++)
            add(1, 21'(k), 0, 0, 0, 1, 21'h1, k, k == 8, 0, 0);
        add(1, 21'd9,  0, 0, 0, 1, 21'd1, 8, 1, 1, 0);
        add(0, 21'd0,  1, 0, 0, 1, 21'd2, 7, 0, 1, 0);
        add(0, 21'd0,  1, 0, 0, 1, 21'd3, 6, 0, 1, 0);
        add(1, 21'd10, 0, 0, 0, 1, 21'd3, 7, 0, 1, 0);
        add(1, 21'd11, 0, 0, 0, 1, 21'd3, 8, 1, 1, 0);
        add(0, 21'd0,  1, 0, 0, 1, 21'd4,  7, 0, 1, 0);
        add(0, 21'd0,  1, 0, 0, 1, 21'd5,  6, 0, 1, 0);
        add(0, 21'd0,  1, 0, 0, 1, 21'd6,  5, 0, 1, 0);
        add(0, 21'd0,  1, 0, 0, 1, 21'd7,  4, 0, 1, 0);
        add(0, 21'd0,  1, 0, 0, 1, 21'd8,  3, 0, 1, 0);
        add(0, 21'd0,  1, 0, 0, 1, 21'd10, 2, 0, 1, 0);
        add(0, 21'd0,  1, 0, 0, 1, 21'd11, 1, 0, 1, 0);
        add(0, 21'd0,  1, 0, 0, 0, 21'd0,  0, 0, 1, 0);
        add(0, 21'd0,  0, 0, 1, 0, 21'd0,  0, 0, 0, 0);
        // simultaneous push and pop while full
        for (int k = 1; k <= 8; k++)
            add(1, 21'h100 + 21'(k), 0, 0, 0, 1, 21'h101, k, k == 8, 0, 0);
        add(1, 21'h1AA, 1, 0, 0, 1, 21'h102, 8, 1, 0, 0);
        for (int k = 3; k <= 8; k++)
            add(0, 21'h0, 1, 0, 0, 1, 21'h100 + 21'(k), 10 - k, 0, 0, 0);
        add(0, 21'h0, 1, 0, 0, 1, 21'h1AA, 1, 0, 0, 0);
        add(0, 21'h0, 1, 0, 0, 0, 21'h0,   0, 0, 0, 0);
        // done arrives with the final push; drained only after both pops
        add(1, 21'h55, 0, 0, 0, 1, 21'h55, 1, 0, 0, 0);
        add(1, 21'h66, 0, 1, 0, 1, 21'h55, 2, 0, 0, 0);
        add(0, 21'h0,  1, 0, 0, 1, 21'h66, 1, 0, 0, 0);
        add(0, 21'h0,  1, 0, 0, 0, 21'h0,  0, 0, 0, 1);
        add(0, 21'h0,  0, 0, 0, 0, 21'h0,  0, 0, 0, 1);
        // clr beats a push and a done pulse in the same cycle
        add(1, 21'h77, 1, 1, 1, 0, 21'h0,  0, 0, 0, 0);
        add(0, 21'h0,  0, 0, 0, 0, 21'h0,  0, 0, 0, 0);

        // reset state
        #1;
        chk_state("rst0", 0, '0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // reset mid-fill: takes effect without a clock edge
        drive(1'b1, 21'h0A1, 1'b0, 1'b1, 1'b0); step();
        drive(1'b1, 21'h0A2, 1'b0, 1'b0, 1'b0); step();
        drive(1'b1, 21'h0A3, 1'b0, 1'b0, 1'b0); step();
        chk("midfill.count", 32'(bus.count), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk_state("midrst", 0, '0, 0, 0, 0, 0);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk_state("postrst", 0, '0, 0, 0, 0, 0);

        // table-driven vectors
        foreach (vecs[i]) begin
            drive(vecs[i].wr_req, vecs[i].wr_data, vecs[i].out_ready,
                  vecs[i].acc_done, vecs[i].clr);
            step();
            chk_state($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data,
                      int'(vecs[i].exp_count), vecs[i].exp_full, vecs[i].exp_ovf,
                      vecs[i].exp_drained);
        end

        // backpressure: head word stays put while the FIFO keeps filling
        drive(1'b1, 21'h11, 1'b0, 1'b0, 1'b0); step();
        for (int i = 0; i < 5; i++) begin
            drive(i != 2, 21'h20 + 21'(i), 1'b0, 1'b0, 1'b0);
            step();
            chk_state($sformatf("bp%0d", i), 1, 21'h11,
                      (i < 2) ? i + 2 : i + 1, 0, 0, 0);
        end
        // remaining order: 11,20,21,23,24
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0); step();
        chk("bp.pop1", 32'(bus.out_data), 32'h20);
        step();
        chk("bp.pop2", 32'(bus.out_data), 32'h21);
        step();
        chk("bp.pop3", 32'(bus.out_data), 32'h23);
        step();
        chk("bp.pop4", 32'(bus.out_data), 32'h24);
        step();
        chk_state("bp.end", 0, '0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
